// File: rtl/resource_request_sequencer_pkg.sv
// Shared codes, widths and FSM states for the resource request sequencer.
package resource_pkg;

    localparam int ENERGY_W = 8;
    localparam int TRACER_W = 6;
    localparam int FLUID_W  = 4;

    localparam logic OP_SPEND    = 1'b0;
    localparam logic OP_RECHARGE = 1'b1;

    localparam logic [1:0] SEL_ENERGY  = 2'd0;
    localparam logic [1:0] SEL_TRACER  = 2'd1;
    localparam logic [1:0] SEL_FLUID   = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        WRITE,
        RESP
    } state_t;

    function automatic logic [7:0] store_max(input int w);
        return 8'((1 << w) - 1);
    endfunction

    localparam logic [7:0] ENERGY_MAX = store_max(ENERGY_W);
    localparam logic [7:0] TRACER_MAX = store_max(TRACER_W);
    localparam logic [7:0] FLUID_MAX  = store_max(FLUID_W);

endpackage

// File: rtl/resource_request_sequencer_if.sv
// Request/response handshake bundle between a requester and the sequencer.
interface resource_request_sequencer_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [1:0] req_sel;
    logic [7:0] req_amt;
    logic       rsp_valid;
    logic       rsp_ok;
    logic       rsp_sat;
    logic [7:0] rsp_balance;

    modport master (
        output req_valid, req_op, req_sel, req_amt,
        input  req_ready, rsp_valid, rsp_ok, rsp_sat, rsp_balance
    );

    modport slave (
        input  req_valid, req_op, req_sel, req_amt,
        output req_ready, rsp_valid, rsp_ok, rsp_sat, rsp_balance
    );

endinterface

// File: rtl/resource_request_sequencer_alu.sv
// Checked subtract / saturating add against a runtime store maximum.
module resource_alu
    import resource_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] max_val,
    input  logic [7:0]   amt,
    input  logic         op,
    output logic [W-1:0] new_val,
    output logic         ok,
    output logic         sat
);

    localparam int SW = ((W > 8) ? W : 8) + 1;

    logic [SW-1:0] qx;
    logic [SW-1:0] ax;
    logic [SW-1:0] mx;
    logic [SW-1:0] sum;
    logic [SW-1:0] diff;

    assign qx   = SW'(q);
    assign ax   = SW'(amt);
    assign mx   = SW'(max_val);
    assign sum  = qx + ax;
    assign diff = qx - ax;

    always_comb begin
        new_val = '0;
        ok      = 1'b0;
        sat     = 1'b0;
        if (op == OP_SPEND) begin
            ok      = (ax <= qx);
            new_val = W'(diff);
        end else begin
            ok = 1'b1;
            if (sum > mx) begin
                sat     = 1'b1;
                new_val = max_val;
            end else begin
                new_val = W'(sum);
            end
        end
    end

endmodule

// File: rtl/resource_request_sequencer.sv
// Spend/recharge front-end for the energy, tracer and fluid stores.
module resource_request_sequencer
    import resource_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    resource_request_sequencer_if.slave req,
    input  logic [ENERGY_W-1:0]  energy_q,
    input  logic [TRACER_W-1:0]  tracer_q,
    input  logic [FLUID_W-1:0]   fluid_q,
    output logic                 energy_en,
    output logic                 tracer_en,
    output logic                 fluid_en,
    output logic [ENERGY_W-1:0]  energy_d,
    output logic [TRACER_W-1:0]  tracer_d,
    output logic [FLUID_W-1:0]   fluid_d,
    output logic [CNT_W-1:0]     deny_count
);

    state_t      state;
    logic        op_r;
    logic [1:0]  sel_r;
    logic [7:0]  amt_r;
    logic        ok_r;
    logic        sat_r;
    logic [2:0]  en_r;
    logic        rsp_valid_r;
    logic        rsp_ok_r;
    logic        rsp_sat_r;
    logic [7:0]  rsp_bal_r;

    logic [7:0]  cur_q;
    logic [7:0]  cur_max;
    logic [7:0]  alu_new;
    logic        alu_ok;
    logic        alu_sat;
    logic        eval_ok;
    logic        eval_sat;

    always_comb begin
        cur_q   = '0;
        cur_max = '0;
        case (sel_r)
            SEL_ENERGY: begin
                cur_q   = 8'(energy_q);
                cur_max = ENERGY_MAX;
            end
            SEL_TRACER: begin
                cur_q   = 8'(tracer_q);
                cur_max = TRACER_MAX;
            end
            SEL_FLUID: begin
                cur_q   = 8'(fluid_q);
                cur_max = FLUID_MAX;
            end
            default: begin
                cur_q   = '0;
                cur_max = '0;
            end
        endcase
    end

    resource_alu #(.W(8)) u_alu (
        .q       (cur_q),
        .max_val (cur_max),
        .amt     (amt_r),
        .op      (op_r),
        .new_val (alu_new),
        .ok      (alu_ok),
        .sat     (alu_sat)
    );

    assign eval_ok  = alu_ok && (sel_r != SEL_ILLEGAL);
    assign eval_sat = alu_sat && eval_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_r        <= 1'b0;
            sel_r       <= '0;
            amt_r       <= '0;
            ok_r        <= 1'b0;
            sat_r       <= 1'b0;
            en_r        <= '0;
            energy_d    <= '0;
            tracer_d    <= '0;
            fluid_d     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_ok_r    <= 1'b0;
            rsp_sat_r   <= 1'b0;
            rsp_bal_r   <= '0;
            deny_count  <= '0;
        end else begin
            en_r        <= '0;
            rsp_valid_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        op_r  <= req.req_op;
                        sel_r <= req.req_sel;
                        amt_r <= req.req_amt;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    ok_r  <= eval_ok;
                    sat_r <= eval_sat;
                    if (eval_ok) begin
                        en_r  <= 3'b001 << sel_r;
                        state <= WRITE;
                        case (sel_r)
                            SEL_ENERGY: energy_d <= alu_new;
                            SEL_TRACER: tracer_d <= alu_new[TRACER_W-1:0];
                            default:    fluid_d  <= alu_new[FLUID_W-1:0];
                        endcase
                    end else begin
                        state <= RESP;
                    end
                end
                WRITE: begin
                    state <= RESP;
                end
                RESP: begin
                    // Store has already taken the write, so cur_q is post-op.
                    rsp_valid_r <= 1'b1;
                    rsp_ok_r    <= ok_r;
                    rsp_sat_r   <= sat_r;
                    rsp_bal_r   <= cur_q;
                    if (!ok_r && (deny_count != '1)) begin
                        deny_count <= deny_count + 1'b1;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

    // A reset landing in WRITE must suppress the store update at that edge.
    assign energy_en = en_r[0] && !reset;
    assign tracer_en = en_r[1] && !reset;
    assign fluid_en  = en_r[2] && !reset;

    assign req.req_ready   = (state == IDLE) && !reset;
    assign req.rsp_valid   = rsp_valid_r;
    assign req.rsp_ok      = rsp_ok_r;
    assign req.rsp_sat     = rsp_sat_r;
    assign req.rsp_balance = rsp_bal_r;

endmodule

// File: doc/resource_request_sequencer.md
Name: resource_request_sequencer

Overview:
- Command front-end placed directly upstream of the energy (8b), spider-tracer (6b) and fluid (4b) storage registers.
- Accepts spend/recharge requests over a valid/ready handshake and checks the spend against the current balance.
- Computes the new value and drives the storage register's enable/load for exactly one cycle, then returns a one-cycle response.
- Keeps a saturating count of denied requests.

Parameters:
ENERGY_W, 8, energy store width
TRACER_W, 6, spider-tracer store width
FLUID_W, 4, fluid store width
CNT_W, 8, deny counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept
req_op  in  1  0=spend, 1=recharge
req_sel  in  2  0=energy, 1=tracer, 2=fluid, 3=illegal
req_amt  in  8  amount, unsigned
energy_q  in  ENERGY_W  current energy store value
tracer_q  in  TRACER_W  current tracer store value
fluid_q  in  FLUID_W  current fluid store value
energy_en / tracer_en / fluid_en  out  1 each  store write enables
energy_d  out  ENERGY_W  energy store load value
tracer_d  out  TRACER_W  tracer store load value
fluid_d  out  FLUID_W  fluid store load value
rsp_valid  out  1  response pulse
rsp_ok  out  1  1=committed, 0=denied
rsp_sat  out  1  recharge clipped at max
rsp_balance  out  8  store value after operation, zero-extended
deny_count  out  CNT_W  saturating count of denied requests

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state=IDLE; all *_en=0, *_d=0, rsp_valid=0, rsp_ok=0, rsp_sat=0, rsp_balance=0, deny_count=0.
  - req_ready=0 while reset is high.
  - A reset mid-operation aborts with no write and no response.
- FSM states: IDLE, EVAL, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op/sel/amt and go to EVAL.
- EVAL:
  - Sample the selected *_q. W = selected width; MAX = 2^W-1.
  - Spend: deny if sel==3 or amt > q (full 8-bit compare; any amt bit at or above W forces deny). Otherwise new = q-amt.
  - Recharge: deny if sel==3. Otherwise new = min(q+amt, MAX), computed at 9 bits; rsp_sat=1 if clipped.
  - amt=0 is legal and writes the unchanged value.
  - Go to WRITE if ok, else RESP.
- WRITE:
  - Exactly one *_en=1, with *_d=new; the store updates at the end of this cycle.
  - Go to RESP.
- RESP:
  - rsp_valid=1 for one cycle.
  - rsp_balance = selected *_q, reflecting the write; equals the unchanged q on deny, 0 for sel==3.
  - If denied, deny_count increments and holds at 2^CNT_W-1.
  - Go to IDLE.
- Latency:
  - Accepted request: rsp_valid 3 cycles after the handshake edge.
  - Denied request: 2 cycles after the handshake edge.
  - Throughput: at most one request per 4 cycles (3 when denied).
- Non-accepted inputs: req_* changes outside the handshake cycle are ignored. rsp_ok/rsp_sat/rsp_balance hold their value until the next RESP.
- Ownership: *_en never asserts outside WRITE. Only this block writes the stores.

Decomposition:
- Shared package resource_pkg holds:
  - op codes OP_SPEND/OP_RECHARGE;
  - sel codes SEL_ENERGY/SEL_TRACER/SEL_FLUID/SEL_ILLEGAL;
  - FSM state enum;
  - width constants ENERGY_W/TRACER_W/FLUID_W.
- One sub-module, resource_alu:
  - parameter W; inputs q, amt[7:0], op;
  - outputs new_val, ok, sat;
  - checked subtract / saturating add, purely combinational.
  - Instantiated once, with the operand zero-extended to 8 bits and the result sliced to W.

Test Plan:
- Reset with the stores at their post-reset value 1: energy spend amt=1 -> ready at cycle 0; energy_en for one cycle with energy_d=0; rsp_ok=1, rsp_balance=0 three cycles after accept.
- Tracer q=40, spend amt=41 -> no tracer_en; rsp_ok=0, rsp_balance=40, deny_count=1. Then fluid q=5, spend amt=16 -> denied (amt exceeds FLUID_W).
- Fluid q=12, recharge amt=9 -> fluid_d=15, rsp_sat=1, rsp_ok=1. Energy q=200, recharge 55 -> 255, rsp_sat=0.
- req_sel=3 with either op -> no enable ever asserts; rsp_ok=0, rsp_balance=0. Repeat 300 times -> deny_count holds at 255.
- req_valid held high with back-to-back requests -> req_ready low in EVAL/WRITE/RESP, second request accepted in the IDLE cycle after RESP; no request lost or duplicated.
- Reset asserted during WRITE (before the edge) -> no store write, no rsp_valid; the next request after reset is handled normally.
